muldiv_seq: RTL and testbench
=============================

MULDIV_SEQ -- requirements
Module: muldiv_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning operand/result width (even, >=4).
REQ-002 SHALL have port clk_i  input  1  clock; all state changes on rising edge.
REQ-003 SHALL have port rst_i  input  1  reset; one clock; reset is synchronous and active-high.
REQ-004 SHALL have port start_i  input  1  request a new operation.
REQ-005 SHALL have port op_i  input  2  operation: 00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU.
REQ-006 SHALL have port a_i  input  WIDTH  multiplicand / dividend.
REQ-007 SHALL have port b_i  input  WIDTH  multiplier / divisor.
REQ-008 SHALL have port busy_o  output  1  operation in progress; high when state != IDLE.
REQ-009 SHALL have port done_o  output  1  one-cycle completion pulse.
REQ-010 SHALL have port hi_o  output  WIDTH  product upper half / remainder.
REQ-011 SHALL have port lo_o  output  WIDTH  product lower half / quotient.
REQ-012 SHALL have port div0_o  output  1  last DIV/DIVU had b_i == 0; present only with MULDIV_DIV0_EN.

Function
REQ-013 SHALL implement states IDLE, CALC, FIX; IDLE->CALC on start_i; CALC->FIX after WIDTH CALC cycles; FIX->IDLE unconditionally.
REQ-014 SHALL accept start_i only in IDLE; op_i/a_i/b_i are captured at that edge, and start_i is ignored while busy_o is high.
REQ-015 SHALL process one result bit per CALC cycle (shift-add multiply, restoring divide on magnitudes), using a counter of clog2(WIDTH) bits that wraps to 0 on CALC exit.
REQ-016 SHALL apply sign correction in FIX: product negated when operand signs differ (signed ops); quotient negated when signs differ, remainder takes sign of dividend.
REQ-017 SHALL produce MULT/MULTU result as the full 2*WIDTH-bit product {hi_o, lo_o}.
REQ-018 SHALL truncate signed quotient toward zero.
REQ-019 SHALL, for DIV with a = signed min and b = -1, give lo_o = signed min and hi_o = 0.
REQ-020 SHALL assert done_o for exactly the first IDLE cycle after FIX; latency = start edge + WIDTH + 2 edges.
REQ-021 SHALL update hi_o/lo_o only on the FIX->IDLE edge and hold them until the next completion; they do not change during CALC.
REQ-022 SHALL accept start_i in the same cycle that done_o is high (back-to-back) with no lost pulse.
REQ-023 SHALL treat a_i/b_i changes after the capture edge as having no effect on the running operation.

Reset
REQ-024 SHALL, with rst_i high at an edge, force state IDLE, counter 0, busy_o 0, done_o 0, hi_o 0, lo_o 0, div0_o 0.
REQ-025 SHALL give reset priority over start_i and abort any in-flight operation without a done_o pulse.

Configuration
REQ-026 SHALL, with MULDIV_DIV0_EN defined, complete DIV/DIVU with b_i == 0 by skipping CALC (IDLE->FIX->IDLE, done_o 2 edges after start) with lo_o = all ones, hi_o = a_i, and div0_o = 1; div0_o clears on any later completion with nonzero divisor or on any MULT/MULTU.
REQ-027 SHALL, without MULDIV_DIV0_EN, omit div0_o and run divide-by-zero for full latency with hi_o/lo_o values unspecified.

Verification (WIDTH=32)
REQ-028 SHALL cover: MULT a=-3 b=7 -> done_o at start+34, hi_o=FFFFFFFF, lo_o=FFFFFFEB.
REQ-029 SHALL cover: MULTU a=FFFFFFFF b=FFFFFFFF -> hi_o=FFFFFFFE, lo_o=00000001.
REQ-030 SHALL cover: DIV a=-7 b=2 -> lo_o=FFFFFFFD, hi_o=FFFFFFFF; then DIV a=80000000 b=FFFFFFFF -> lo_o=80000000, hi_o=0.
REQ-031 SHALL cover: DIVU a=100 b=7 issued when done_o high after prior op, with start_i pulsed again mid-run -> single done_o, lo_o=14, hi_o=2.
REQ-032 SHALL cover: rst_i at start+10 of MULT -> no done_o, hi_o=lo_o=0, busy_o=0 next cycle.
REQ-033 SHALL cover: DIVU a=5 b=0 with MULDIV_DIV0_EN -> done_o at start+2, lo_o=FFFFFFFF, hi_o=5, div0_o=1.

Source files
------------

// File: rtl/muldiv_seq.sv
// Sequential radix-2 multiplier/divider: one result bit per cycle, sign fix-up in a final FIX cycle.
// Optional MULDIV_DIV0_EN: fast divide-by-zero completion with a sticky-until-next-op div0_o flag.
module muldiv_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
`ifdef MULDIV_DIV0_EN
    ,
    output logic             div0_o
`endif
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } state_e;

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]  acc_q, acc_d;      // product high half / partial remainder
    logic [WIDTH-1:0]  sh_q, sh_d;        // multiplier bits / quotient bits
    logic [WIDTH-1:0]  bmag_q, bmag_d;
    logic              is_div_q, is_div_d;
    logic              neg_res_q, neg_res_d;
    logic              neg_rem_q, neg_rem_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [WIDTH-1:0]  hi_q, hi_d;
    logic [WIDTH-1:0]  lo_q, lo_d;
`ifdef MULDIV_DIV0_EN
    logic              zdiv_q, zdiv_d;
    logic              div0_q, div0_d;
`endif

    logic              a_neg_s, b_neg_s;
    logic [WIDTH-1:0]  a_mag_s, b_mag_s;
    logic [WIDTH:0]    mul_sum_s;
    logic [WIDTH:0]    div_shift_s;
    logic              div_ge_s;
    logic [2*WIDTH-1:0] prod_s, prod_neg_s;

    // Operand magnitudes and per-cycle datapath terms
    always_comb begin
        a_neg_s     = ~op_i[0] & a_i[WIDTH-1];
        b_neg_s     = ~op_i[0] & b_i[WIDTH-1];
        a_mag_s     = a_neg_s ? (-a_i) : a_i;
        b_mag_s     = b_neg_s ? (-b_i) : b_i;
        if (sh_q[0]) begin
            mul_sum_s = {1'b0, acc_q} + {1'b0, bmag_q};
        end else begin
            mul_sum_s = {1'b0, acc_q};
        end
        div_shift_s = {acc_q, sh_q[WIDTH-1]};
        div_ge_s    = (div_shift_s >= {1'b0, bmag_q});
        prod_s      = {acc_q, sh_q};
        prod_neg_s  = -prod_s;
    end

    // Next-state, datapath and result logic
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        sh_d      = sh_q;
        bmag_d    = bmag_q;
        is_div_d  = is_div_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        done_d    = 1'b0;
        hi_d      = hi_q;
        lo_d      = lo_q;
`ifdef MULDIV_DIV0_EN
        zdiv_d    = zdiv_q;
        div0_d    = div0_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    is_div_d  = op_i[1];
                    neg_res_d = a_neg_s ^ b_neg_s;
                    neg_rem_d = a_neg_s;
                    acc_d     = '0;
                    sh_d      = a_mag_s;
                    bmag_d    = b_mag_s;
                    cnt_d     = '0;
                    state_d   = S_CALC;
`ifdef MULDIV_DIV0_EN
                    // Zero divisor skips CALC; keep the raw dividend for hi_o
                    if (op_i[1] && (b_i == '0)) begin
                        zdiv_d  = 1'b1;
                        sh_d    = a_i;
                        state_d = S_FIX;
                    end else begin
                        zdiv_d  = 1'b0;
                    end
`endif
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_CALC: begin
                if (is_div_q) begin
                    acc_d = div_ge_s ? (div_shift_s[WIDTH-1:0] - bmag_q) : div_shift_s[WIDTH-1:0];
                    sh_d  = {sh_q[WIDTH-2:0], div_ge_s};
                end else begin
                    acc_d = mul_sum_s[WIDTH:1];
                    sh_d  = {mul_sum_s[0], sh_q[WIDTH-1:1]};
                end
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = S_FIX;
                end else begin
                    cnt_d   = cnt_q + CW'(1);
                end
            end
            S_FIX: begin
                state_d = S_IDLE;
                done_d  = 1'b1;
                if (is_div_q) begin
                    lo_d = neg_res_q ? (-sh_q) : sh_q;
                    hi_d = neg_rem_q ? (-acc_q) : acc_q;
                end else begin
                    {hi_d, lo_d} = neg_res_q ? prod_neg_s : prod_s;
                end
`ifdef MULDIV_DIV0_EN
                div0_d = zdiv_q;
                if (zdiv_q) begin
                    lo_d = '1;
                    hi_d = sh_q;
                end else begin
                    lo_d = lo_d;
                end
`endif
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            sh_q      <= '0;
            bmag_q    <= '0;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
`ifdef MULDIV_DIV0_EN
            zdiv_q    <= 1'b0;
            div0_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            sh_q      <= sh_d;
            bmag_q    <= bmag_d;
            is_div_q  <= is_div_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
`ifdef MULDIV_DIV0_EN
            zdiv_q    <= zdiv_d;
            div0_q    <= div0_d;
`endif
        end
    end

    assign busy_o = busy_q;
    assign done_o = done_q;
    assign hi_o   = hi_q;
    assign lo_o   = lo_q;
`ifdef MULDIV_DIV0_EN
    assign div0_o = div0_q;
`endif

endmodule

// File: tb/tb_muldiv_seq.sv
// Scoreboard bench for muldiv_seq (WIDTH=32): directed vectors pushed at issue, checked on done_o.
// Define MULDIV_DIV0_EN to also exercise the divide-by-zero fast path.
module tb_muldiv_seq;
    localparam int W = 32;
    localparam logic [1:0] OP_MULT = 2'b00, OP_MULTU = 2'b01, OP_DIV = 2'b10, OP_DIVU = 2'b11;

    logic         clk = 1'b0;
    logic         rst, start;
    logic [1:0]   op;
    logic [W-1:0] a, b, hi, lo;
    logic         busy, done;
`ifdef MULDIV_DIV0_EN
    logic         div0;
`endif

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        int           issue;
        int           lat;
        logic         div0;
    } exp_t;
    exp_t sb[$];

    muldiv_seq #(.WIDTH(W)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .op_i(op), .a_i(a), .b_i(b),
        .busy_o(busy), .done_o(done), .hi_o(hi), .lo_o(lo)
`ifdef MULDIV_DIV0_EN
        , .div0_o(div0)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every done_o cycle must match the oldest outstanding expectation
    always @(negedge clk) begin
        exp_t e;
        if (done === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done_o=1 expected 0 (cycle %0d)", cyc);
            end else begin
                e = sb.pop_front();
                check("hi_o", hi, e.hi);
                check("lo_o", lo, e.lo);
                check("latency", W'(cyc - e.issue), W'(e.lat));
                check("busy_at_done", {31'd0, busy}, 32'd0);
`ifdef MULDIV_DIV0_EN
                check("div0_o", {31'd0, div0}, {31'd0, e.div0});
`endif
            end
        end
    end

    // Present one operation for a single cycle; operands are scrambled afterwards
    task automatic issue(input logic [1:0] o, input logic [W-1:0] av, input logic [W-1:0] bv,
                         input logic [W-1:0] ehi, input logic [W-1:0] elo, input int lat,
                         input logic ediv0);
        exp_t e;
        start = 1'b1;
        op    = o;
        a     = av;
        b     = bv;
        e.hi = ehi; e.lo = elo; e.issue = cyc; e.lat = lat; e.div0 = ediv0;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
        op    = 2'($urandom);
        a     = $urandom;
        b     = $urandom;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL timeout: got %0d pending results expected 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic run(input logic [1:0] o, input logic [W-1:0] av, input logic [W-1:0] bv,
                       input logic [W-1:0] ehi, input logic [W-1:0] elo);
        issue(o, av, bv, ehi, elo, W + 2, 1'b0);
        wait_idle();
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0;
        repeat (2) @(negedge clk);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_hi", hi, 32'd0);
        check("reset_lo", lo, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Signed multiply, with outputs held and busy during CALC
        issue(OP_MULT, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, W + 2, 1'b0);
        repeat (10) @(negedge clk);
        check("busy_mid", {31'd0, busy}, 32'd1);
        check("hold_hi_mid", hi, 32'd0);
        check("hold_lo_mid", lo, 32'd0);
        wait_idle();

        run(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
        run(OP_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD);

        // Overflow divide, then back-to-back DIVU issued on its done cycle
        issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, W + 2, 1'b0);
        begin
            int n = 0;
            while (done !== 1'b1 && n < 60) begin
                @(negedge clk);
                n++;
            end
            if (done !== 1'b1) begin
                checks++;
                errors++;
                $display("FAIL b2b_wait: got done_o=%b expected 1", done);
            end
        end
        issue(OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, W + 2, 1'b0);
        repeat (5) @(negedge clk);
        start = 1'b1; op = OP_MULT; a = 32'd9; b = 32'd9;
        @(negedge clk);
        start = 1'b0;
        wait_idle();

        run(OP_MULT,  32'd12345,     32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_9F8E);
        run(OP_DIV,   32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD);
        run(OP_DIV,   32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0003);
        run(OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);
        run(OP_MULTU, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000);
        run(OP_DIVU,  32'hFFFF_FFFF, 32'd1,         32'h0000_0000, 32'hFFFF_FFFF);
        run(OP_DIVU,  32'd3,         32'd10,        32'h0000_0003, 32'h0000_0000);
        run(OP_MULT,  32'd0,         32'hFFFF_FFFB, 32'h0000_0000, 32'h0000_0000);

        // Reset aborts an in-flight multiply without a completion
        run(OP_MULTU, 32'd6, 32'd7, 32'd0, 32'd42);
        issue(OP_MULT, 32'd5, 32'd5, 32'd0, 32'd25, W + 2, 1'b0);
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        check("abort_hi", hi, 32'd0);
        check("abort_lo", lo, 32'd0);
        repeat (40) @(negedge clk);

`ifdef MULDIV_DIV0_EN
        issue(OP_DIVU, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 2, 1'b1);
        wait_idle();
        check("div0_held", {31'd0, div0}, 32'd1);
        run(OP_MULT, 32'd2, 32'd3, 32'd0, 32'd6);
`endif

        run(OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish expected finish by 500000");
        $fatal(1, "timeout");
    end

endmodule
